uart_tx: RTL and testbench

//  UART transmitter, the send side of the board's serial link (8 data bits, LSB first, optional even parity,
//  1 stop bit). Accepts bytes from game logic through a small sync FIFO and serialises them onto o_uart_tx.

---
 rtl/uart_tx_pkg.sv | 28 ++
 rtl/uart_tx_if.sv | 16 +
 rtl/uart_tx_fifo.sv | 60 ++++++
 rtl/uart_tx.sv | 140 ++++++++++++++
 tb/tb_uart_tx.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the serial link transmitter.
// Holds the FSM state encoding, which uses the same values as the receiver,
// the default line settings, and small helpers for baud derivation and parity.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int unsigned DEF_CLK_FREQ  = 32'd25_000_000;
  localparam int unsigned DEF_BAUD_RATE = 32'd9600;

  // Clock cycles per bit period, truncated (2604 at the defaults).
  function automatic int unsigned clks_per_baud(input int unsigned clk_freq,
                                                input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Even parity bit: makes the total count of ones (data + parity) even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-side bus of the transmitter.
//   wr    : write strobe, byte accepted on a clock edge where wr=1 and full=0
//   data  : byte to send, sampled with wr
//   full  : FIFO full, writes while full are dropped
//   busy  : FIFO non-empty or a frame on the line
//   tx    : serial line, idles high
interface uart_tx_if;
  logic       wr;
  logic [7:0] data;
  logic       full;
  logic       busy;
  logic       tx;

  modport master (output wr, data, input full, busy, tx);
  modport slave  (input wr, data, output full, busy, tx);
endinterface

// File: rtl/uart_tx_fifo.sv
// Count-based synchronous FIFO, reusable for a receive buffer.
//   i_clk, rst : clock, synchronous active-low reset
//   push/wdata : write request and data (ignored while full)
//   pop/rdata  : read request (ignored while empty); rdata shows the head
//   full/empty : compares on the registered occupancy count
//   count      : registered occupancy, 0..2**AW
module uart_tx_fifo #(
  parameter int AW = 2,
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == (AW+1)'(0));
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at 2**AW.
  always_ff @(posedge i_clk) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge i_clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= wdata;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional even parity, 1 stop bit.
// Bytes are queued in a small FIFO and serialised onto bus.tx.
//   i_clk : system clock, all logic on posedge
//   rst   : synchronous active-low reset; aborts any frame and flushes the FIFO
//   bus   : slave side of uart_tx_if (wr/data in, full/busy/tx out)
// The line flop is loaded from the level of the *current* state, so the line
// trails the FSM by one clock: a write into an idle, empty block shows the
// start bit two clocks after the write edge (enqueue, then IDLE pop).
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = DEF_CLK_FREQ,
  parameter int unsigned BAUD_RATE = DEF_BAUD_RATE,
  parameter bit          PARITY_EN = 1'b0,
  parameter int          FIFO_AW   = 2
) (
  input logic     i_clk,
  input logic     rst,
  uart_tx_if.slave bus
);

  localparam int unsigned CPB = clks_per_baud(CLK_FREQ, BAUD_RATE);
  localparam int          CW  = (CPB > 1) ? $clog2(CPB) : 1;

  tx_state_e        state_r, state_n;
  logic [CW-1:0]    baud_cnt_r;
  logic [2:0]       bit_cnt_r;
  logic [7:0]       shreg_r;
  logic             par_r;
  logic             tx_r;
  logic             busy_r;
  logic             line_s;
  logic             baud_wrap_s;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;
  logic [7:0]       head_s;
  logic [FIFO_AW:0] count_s;
  logic [FIFO_AW:0] cnt_n;

  assign baud_wrap_s = (baud_cnt_r == CW'(CPB - 1));
  assign push_s      = bus.wr && !full_s;
  assign pop_s       = (state_r == ST_IDLE) && !empty_s;

  assign bus.full = full_s;
  assign bus.busy = busy_r;
  assign bus.tx   = tx_r;

  uart_tx_fifo #(.AW(FIFO_AW), .DW(8)) u_fifo (
    .i_clk (i_clk),
    .rst   (rst),
    .push  (push_s),
    .wdata (bus.data),
    .pop   (pop_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // FIFO occupancy after this edge, used so busy rises the cycle after a write.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   cnt_n = count_s + (FIFO_AW+1)'(1);
      2'b01:   cnt_n = count_s - (FIFO_AW+1)'(1);
      default: cnt_n = count_s;
    endcase
  end

  // Next-state logic and the line level belonging to the current state.
  always_comb begin
    state_n = state_r;
    line_s  = 1'b1;
    case (state_r)
      ST_IDLE: begin
        line_s = 1'b1;
        if (pop_s) state_n = ST_START;
        else       state_n = ST_IDLE;
      end
      ST_START: begin
        line_s = 1'b0;
        if (baud_wrap_s) state_n = ST_DATA;
        else             state_n = ST_START;
      end
      ST_DATA: begin
        line_s = shreg_r[0];
        if (baud_wrap_s && (bit_cnt_r == 3'd7)) begin
          if (PARITY_EN) state_n = ST_PARITY;
          else           state_n = ST_STOP;
        end else begin
          state_n = ST_DATA;
        end
      end
      ST_PARITY: begin
        line_s = par_r;
        if (baud_wrap_s) state_n = ST_STOP;
        else             state_n = ST_PARITY;
      end
      ST_STOP: begin
        line_s = 1'b1;
        if (baud_wrap_s) state_n = ST_IDLE;
        else             state_n = ST_STOP;
      end
      default: begin
        line_s  = 1'b1;
        state_n = ST_IDLE;
      end
    endcase
  end

  // State register, baud/bit counters, shift register, parity and output flops.
  always_ff @(posedge i_clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      baud_cnt_r <= '0;
      bit_cnt_r  <= 3'd0;
      shreg_r    <= 8'h00;
      par_r      <= 1'b0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r <= state_n;
      tx_r    <= line_s;
      busy_r  <= (state_n != ST_IDLE) || (cnt_n != (FIFO_AW+1)'(0));
      // Counter sits at 0 in IDLE so START always gets a full bit period.
      if ((state_r == ST_IDLE) || baud_wrap_s) baud_cnt_r <= '0;
      else                                     baud_cnt_r <= baud_cnt_r + CW'(1);
      if (pop_s) begin
        shreg_r   <= head_s;
        par_r     <= even_parity(head_s);
        bit_cnt_r <= 3'd0;
      end else if ((state_r == ST_DATA) && baud_wrap_s) begin
        shreg_r   <= {1'b0, shreg_r[7:1]};
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (parity off / parity on) share one stimulus.
// A frame-level reference model (byte queue + frame start timestamps) predicts
// line, busy and full every cycle; a vector table and a few hand sequences
// check bit values, latency, overflow and mid-frame reset explicitly.
module tb_uart_tx;

  localparam int CLK_FREQ  = 80;
  localparam int BAUD_RATE = 10;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;
  localparam int DEPTH     = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] data = 8'h00;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  uart_tx_if bus0 ();
  uart_tx_if bus1 ();
  assign bus0.wr = wr;
  assign bus0.data = data;
  assign bus1.wr = wr;
  assign bus1.data = data;

  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .PARITY_EN(1'b0), .FIFO_AW(2))
    dut0 (.i_clk(clk), .rst(rst), .bus(bus0.slave));
  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .PARITY_EN(1'b1), .FIFO_AW(2))
    dut1 (.i_clk(clk), .rst(rst), .bus(bus1.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mbuf [2][16];
  int          mhead [2];
  int          mcnt [2];
  int          fstart [2];
  int          nbits [2];
  bit          active [2];
  logic [10:0] fbits [2];
  logic        exp_tx [2];
  logic        exp_busy [2];
  logic        exp_full [2];
  int          cyc = 0;
  bit          mvalid = 1'b0;

  // Each negedge: compare against the prediction for the last posedge, then
  // predict the next posedge from the inputs that it will sample.
  initial begin
    nbits[0] = 10;
    nbits[1] = 11;
    forever begin
      @(negedge clk);
      if (mvalid) begin
        chk("tx_p0",   bus0.tx,   exp_tx[0]);
        chk("busy_p0", bus0.busy, exp_busy[0]);
        chk("full_p0", bus0.full, exp_full[0]);
        chk("tx_p1",   bus1.tx,   exp_tx[1]);
        chk("busy_p1", bus1.busy, exp_busy[1]);
        chk("full_p1", bus1.full, exp_full[1]);
      end
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (!rst) begin
          mcnt[d] = 0; mhead[d] = 0; active[d] = 1'b0;
          exp_tx[d] = 1'b1; exp_busy[d] = 1'b0; exp_full[d] = 1'b0;
        end else begin
          bit full_before;
          int k;
          full_before = (mcnt[d] == DEPTH);
          if ((!active[d] || cyc >= fstart[d] + nbits[d]*CPB + 1) && mcnt[d] > 0) begin
            logic [7:0] b;
            b = mbuf[d][mhead[d]];
            mhead[d] = (mhead[d] + 1) % 16;
            mcnt[d]--;
            fstart[d] = cyc;
            active[d] = 1'b1;
            if (d == 1) fbits[d] = {1'b1, ^b, b, 1'b0};
            else        fbits[d] = {2'b01, b, 1'b0};
          end
          if (wr && !full_before) begin
            mbuf[d][(mhead[d] + mcnt[d]) % 16] = data;
            mcnt[d]++;
          end
          k = cyc - (fstart[d] + 1);
          if (active[d] && k >= 0 && k < nbits[d]*CPB) exp_tx[d] = fbits[d][k / CPB];
          else                                         exp_tx[d] = 1'b1;
          exp_busy[d] = (mcnt[d] > 0) || (active[d] && cyc < fstart[d] + nbits[d]*CPB);
          exp_full[d] = (mcnt[d] == DEPTH);
        end
      end
      if (!rst) mvalid = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic write_byte(input logic [7:0] b);
    @(posedge clk); #1;
    wr = 1'b1; data = b;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while ((bus0.busy || bus1.busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus0.busy || bus1.busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: still busy after %0d cycles", budget);
    end
  endtask

  typedef struct {
    logic [7:0] byte_in;
    logic       par_exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int kcur;
    vecs[0] = '{8'h55, 1'b0};
    vecs[1] = '{8'hA3, 1'b0};
    vecs[2] = '{8'h07, 1'b1};
    vecs[3] = '{8'hC3, 1'b0};
    vecs[4] = '{8'h00, 1'b0};
    vecs[5] = '{8'hFF, 1'b0};
    vecs[6] = '{8'h80, 1'b1};
    vecs[7] = '{8'h01, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_tx0", bus0.tx, 1'b1);
    chk("rst_busy0", bus0.busy, 1'b0);
    chk("rst_full0", bus0.full, 1'b0);
    chk("rst_tx1", bus1.tx, 1'b1);

    // Table: single byte into an idle block, bits sampled mid-period
    for (int v = 0; v < 8; v++) begin
      wait_idle(400);
      write_byte(vecs[v].byte_in);
      @(posedge clk); @(negedge clk);
      chk("lat_hi0", bus0.tx, 1'b1);
      chk("lat_hi1", bus1.tx, 1'b1);
      @(posedge clk); @(negedge clk);
      chk("lat_lo0", bus0.tx, 1'b0);
      chk("lat_lo1", bus1.tx, 1'b0);
      kcur = 0;
      for (int j = 0; j < 11; j++) begin
        logic e0, e1;
        repeat (j*CPB + CPB/2 - kcur) @(negedge clk);
        kcur = j*CPB + CPB/2;
        if (j == 0)      begin e0 = 1'b0; e1 = 1'b0; end
        else if (j <= 8) begin e0 = vecs[v].byte_in[j-1]; e1 = e0; end
        else if (j == 9) begin e0 = 1'b1; e1 = vecs[v].par_exp; end
        else             begin e0 = 1'b1; e1 = 1'b1; end
        chk("bit_p0", bus0.tx, e0);
        chk("bit_p1", bus1.tx, e1);
      end
    end

    // Back-to-back: four writes on consecutive cycles
    wait_idle(400);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 wr = 1'b1; data = 8'(i + 1);
    end
    @(posedge clk); #1 wr = 1'b0;

    // Overflow: hold wr for 8 cycles with 0x10..0x17
    wait_idle(800);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 wr = 1'b1; data = 8'(8'h10 + i);
    end
    @(posedge clk); #1 wr = 1'b0;
    @(negedge clk);
    chk("ovf_full0", bus0.full, 1'b1);
    chk("ovf_full1", bus1.full, 1'b1);

    // Reset during data bit 3 with another byte queued
    wait_idle(800);
    write_byte(8'h5A);
    write_byte(8'h3C);
    repeat (4*CPB + 2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("mrst_tx0", bus0.tx, 1'b1);
    chk("mrst_busy0", bus0.busy, 1'b0);
    chk("mrst_full0", bus0.full, 1'b0);
    chk("mrst_tx1", bus1.tx, 1'b1);
    chk("mrst_busy1", bus1.busy, 1'b0);
    repeat (6) @(negedge clk);
    chk("mrst_flush0", bus0.busy, 1'b0);
    chk("mrst_flush1", bus1.tx, 1'b1);
    write_byte(8'hC3);
    wait_idle(400);

    // Random traffic, gaps from back-to-back to long idle
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(0, 60)) @(posedge clk);
      write_byte(8'($urandom));
    end
    wait_idle(2000);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
